dreq_serializer: RTL and testbench

DREQ_SERIALIZER -- requirements
Module: dreq_serializer

---
 rtl/dreq_serializer.sv | 174 +++++++++++++++++
 tb/tb_dreq_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dreq_serializer.sv
// -----------------------------------------------------------------------------
// dreq_serializer
//
// Serializes the two data-bus requests of a memory-stage instruction pair onto
// a single-port data bus. Slot 1 (older) always goes first, then slot 0
// (younger). Only one bus transaction is ever outstanding. The response data
// of each slot is latched into rdata and held until the next pair completes.
//
// Configuration macro:
//   DREQ_EXCP_KILL_EN  defined   -> excp_in kills the younger (slot 0) request
//                      undefined -> excp_in is ignored, both slots are issued
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   dreq_in  in   [1:0] dbus_req_t, index 1 = older slot, index 0 = younger
//   excp_in  in   exception/ERET in the pair (kills slot 0 when enabled)
//   dreq     out  single-port bus request (valid, addr, size, strobe, data)
//   dresp    in   bus response (addr_ok, data_ok, data)
//   rdata    out  [1:0][31:0] captured response data per slot
//   stall    out  high while any valid slot request is incomplete
//
// Upstream must hold dreq_in/excp_in stable while stall is high; the inputs
// are not registered here, so dreq is a combinational view of dreq_in.
// -----------------------------------------------------------------------------

package dreq_serializer_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

module dreq_serializer
  import dreq_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t [1:0]  dreq_in,
  input  logic             excp_in,
  output dbus_req_t        dreq,
  input  dbus_resp_t       dresp,
  output logic [1:0][31:0] rdata,
  output logic             stall
);

  typedef enum logic [2:0] {
    IDLE,
    REQ1,
    WAIT1,
    REQ0,
    WAIT0,
    DONE
  } state_t;

  state_t state;
  state_t state_n;
  logic   kill;
  logic   slot0_go;
  logic   cap1;
  logic   cap0;

`ifdef DREQ_EXCP_KILL_EN
  assign kill = excp_in;
`else
  // Exception kill disabled: excp_in is deliberately left unobserved.
  logic unused_excp;
  assign unused_excp = excp_in;
  assign kill        = 1'b0;
`endif

  // Slot 0 is only worth issuing when valid and not killed by an exception.
  assign slot0_go = dreq_in[0].valid & ~kill;

  // NOTE: state and rdata are clocked registers, so they use non-blocking
  // assignments; the combinational block below uses blocking ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rdata <= '0;
    end else begin
      state <= state_n;
      if (cap1) rdata[1] <= dresp.data;
      if (cap0) rdata[0] <= dresp.data;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    state_n = state;
    dreq    = '0;
    stall   = 1'b0;
    cap1    = 1'b0;
    cap0    = 1'b0;

    unique case (state)
      IDLE: begin
        stall = dreq_in[1].valid | slot0_go;
        if (dreq_in[1].valid)  state_n = REQ1;
        else if (slot0_go)     state_n = REQ0;
      end

      REQ1: begin
        stall      = 1'b1;
        dreq       = dreq_in[1];
        dreq.valid = 1'b1;
        if (dresp.addr_ok) begin
          if (dresp.data_ok) begin
            // Same-cycle data: skip WAIT1 entirely.
            cap1    = 1'b1;
            state_n = slot0_go ? REQ0 : DONE;
          end else begin
            state_n = WAIT1;
          end
        end
      end

      WAIT1: begin
        stall = 1'b1;
        if (dresp.data_ok) begin
          cap1    = 1'b1;
          state_n = slot0_go ? REQ0 : DONE;
        end
      end

      REQ0: begin
        stall      = 1'b1;
        dreq       = dreq_in[0];
        dreq.valid = 1'b1;
        if (dresp.addr_ok) begin
          if (dresp.data_ok) begin
            cap0    = 1'b1;
            state_n = DONE;
          end else begin
            state_n = WAIT0;
          end
        end
      end

      WAIT0: begin
        stall = 1'b1;
        if (dresp.data_ok) begin
          cap0    = 1'b1;
          state_n = DONE;
        end
      end

      // One-cycle bubble: lets upstream advance before inputs are looked at
      // again, so a held-over pair is never reissued.
      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase

    // Outputs are quiet during the reset cycle regardless of the old state.
    if (reset) begin
      stall = 1'b0;
      dreq  = '0;
    end
  end

endmodule

// File: tb/tb_dreq_serializer.sv
// -----------------------------------------------------------------------------
// tb_dreq_serializer
//
// Self-checking bench for dreq_serializer. Each pair of requests pushes the
// bus transactions it should produce (in slot order, with the slave's
// per-transaction latencies and response data) onto a scoreboard queue. A
// small bus-slave loop pops an entry whenever the DUT raises dreq.valid,
// compares the request, answers with addr_ok/data_ok after the listed delays,
// and at the end the captured rdata and stall length are compared against
// the model.
// -----------------------------------------------------------------------------

module tb_dreq_serializer;
  import dreq_serializer_pkg::*;

  logic             clk;
  logic             reset;
  dbus_req_t [1:0]  dreq_in;
  logic             excp_in;
  dbus_req_t        dreq;
  dbus_resp_t       dresp;
  logic [1:0][31:0] rdata;
  logic             stall;

  dreq_serializer dut (
    .clk     (clk),
    .reset   (reset),
    .dreq_in (dreq_in),
    .excp_in (excp_in),
    .dreq    (dreq),
    .dresp   (dresp),
    .rdata   (rdata),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    dbus_req_t   req;
    int          lat;   // cycles in REQ before addr_ok
    int          gap;   // cycles from addr_ok to data_ok (0 = same cycle)
    logic [31:0] rd;
  } txn_t;

  txn_t             exp_q[$];
  logic [1:0][31:0] exp_rdata;
  int               n_tests;
  int               n_fail;

  task automatic check(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic dbus_req_t mk(input logic v, input logic [31:0] a,
                                   input logic [2:0] sz, input logic [3:0] st,
                                   input logic [31:0] d);
    dbus_req_t r;
    r.valid  = v;
    r.addr   = a;
    r.size   = sz;
    r.strobe = st;
    r.data   = d;
    return r;
  endfunction

  // Drive one pair, act as the bus slave until the DUT drops stall, then
  // compare rdata and the stall length.
  task automatic run_pair(input string name, input dbus_req_t r1,
                          input dbus_req_t r0, input logic ex,
                          input int lat1, input int gap1,
                          input int lat0, input int gap0,
                          input logic [31:0] d1, input logic [31:0] d0);
    txn_t t;
    txn_t cur;
    int   phase;
    int   cnt;
    int   stall_cycles;
    int   exp_stall;
    bit   done;
    bit   kill;

    kill = 1'b0;
`ifdef DREQ_EXCP_KILL_EN
    kill = ex;
`endif
    @(negedge clk);
    dreq_in[1] = r1;
    dreq_in[0] = r0;
    excp_in    = ex;
    dresp      = '0;
    exp_stall  = 1;  // the IDLE cycle that sees the pair
    if (r1.valid) begin
      t.req = r1; t.lat = lat1; t.gap = gap1; t.rd = d1;
      exp_q.push_back(t);
      exp_rdata[1] = d1;
      exp_stall += lat1 + 1 + gap1;
    end
    if (r0.valid && !kill) begin
      t.req = r0; t.lat = lat0; t.gap = gap0; t.rd = d0;
      exp_q.push_back(t);
      exp_rdata[0] = d0;
      exp_stall += lat0 + 1 + gap0;
    end

    phase = 0; cnt = 0; stall_cycles = 0; done = 1'b0;
    cur = '{req: '0, lat: 0, gap: 0, rd: '0};
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
        check({name, " done dreq.valid"}, 96'(dreq.valid), 96'(1'b0));
      end else begin
        stall_cycles++;
        dresp = '0;
        if (phase == 0 && dreq.valid) begin
          check({name, " issue expected"}, 96'(exp_q.size() != 0), 96'(1'b1));
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          else cur = '{req: dreq, lat: 0, gap: 0, rd: '0};
          check({name, " issue addr"}, 96'(dreq.addr), 96'(cur.req.addr));
          phase = 1;
          cnt   = 0;
        end
        if (phase == 1) begin
          check({name, " dreq stable"}, 96'(dreq), 96'(cur.req));
          if (cnt == cur.lat) begin
            dresp.addr_ok = 1'b1;
            if (cur.gap == 0) begin
              dresp.data_ok = 1'b1;
              dresp.data    = cur.rd;
              phase         = 0;
            end else begin
              phase = 2;
              cnt   = 0;
            end
          end else begin
            cnt++;
          end
        end else if (phase == 2) begin
          check({name, " valid dropped"}, 96'(dreq.valid), 96'(1'b0));
          cnt++;
          if (cnt == cur.gap) begin
            dresp.data_ok = 1'b1;
            dresp.data    = cur.rd;
            phase         = 0;
          end
        end
      end
      if (!done) @(negedge clk);
    end

    check({name, " finished in budget"}, 96'(done), 96'(1'b1));
    check({name, " stall cycles"}, 96'(stall_cycles), 96'(exp_stall));
    check({name, " all issued"}, 96'(exp_q.size()), 96'(0));
    check({name, " rdata1"}, 96'(rdata[1]), 96'(exp_rdata[1]));
    check({name, " rdata0"}, 96'(rdata[0]), 96'(exp_rdata[0]));
    exp_q.delete();

    // DONE cycle observed; release the pair and confirm nothing is reissued.
    dreq_in = '0;
    excp_in = 1'b0;
    dresp   = '0;
    @(negedge clk);
    #1;
    check({name, " post-done stall"}, 96'(stall), 96'(1'b0));
    check({name, " post-done valid"}, 96'(dreq.valid), 96'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_rdata = '0;
    reset     = 1'b1;
    dreq_in   = '0;
    excp_in   = 1'b0;
    dresp     = '0;

    // Reset: stall low during reset even with a valid pair presented.
    @(negedge clk);
    dreq_in[1] = mk(1'b1, 32'h0000_1000, 3'd2, 4'h0, 32'h0);
    #1;
    check("reset stall", 96'(stall), 96'(1'b0));
    check("reset dreq", 96'(dreq), 96'(0));
    @(negedge clk);
    dreq_in = '0;
    reset   = 1'b0;
    #1;
    check("after reset stall", 96'(stall), 96'(1'b0));
    check("after reset rdata", 96'(rdata), 96'(0));

    // Dual load: slave needs one extra cycle to accept the first request,
    // then addr_ok/data_ok come one cycle apart: 1+2+1+1+1 = 6 stall cycles.
    run_pair("dual_load",
             mk(1'b1, 32'h0000_1000, 3'd2, 4'h0, 32'h0),
             mk(1'b1, 32'h0000_2000, 3'd2, 4'h0, 32'h0), 1'b0,
             1, 1, 0, 1, 32'hAAAA_0000, 32'h5555_FFFF);

    // Single slot-0 load, addr_ok and data_ok together: IDLE, REQ0, DONE.
    run_pair("slot0_fast",
             mk(1'b0, 32'h0, 3'd0, 4'h0, 32'h0),
             mk(1'b1, 32'h0000_3004, 3'd2, 4'h0, 32'h0), 1'b0,
             0, 0, 0, 0, 32'h0, 32'h1234_5678);

    // Slot-1 store, addr_ok held off 3 cycles: request stable for 4 cycles.
    run_pair("store_slow",
             mk(1'b1, 32'h0000_4000, 3'd2, 4'hF, 32'hDEAD_BEEF),
             mk(1'b0, 32'h0, 3'd0, 4'h0, 32'h0), 1'b0,
             3, 1, 0, 0, 32'h00C0_FFEE, 32'h0);

    // Slot 1 completes in one cycle, slot 0 waits two cycles for data.
    run_pair("mixed_timing",
             mk(1'b1, 32'h0000_5001, 3'd0, 4'h0, 32'h0),
             mk(1'b1, 32'h0000_6002, 3'd1, 4'h0, 32'h0), 1'b0,
             0, 0, 1, 2, 32'h0000_00A5, 32'h0000_BEEF);

    // Exception with both slots valid: slot 0 dropped only when kill enabled.
    run_pair("excp_pair",
             mk(1'b1, 32'h0000_7000, 3'd2, 4'h0, 32'h0),
             mk(1'b1, 32'h0000_8000, 3'd2, 4'h0, 32'h0), 1'b1,
             0, 1, 0, 1, 32'h7777_0001, 32'h8888_0002);

    // Reset while waiting for slot-1 data; late data_ok must be dropped.
    @(negedge clk);
    dreq_in[1] = mk(1'b1, 32'h0000_9000, 3'd2, 4'h0, 32'h0);
    @(negedge clk);
    #1;
    check("rst_mid REQ1 valid", 96'(dreq.valid), 96'(1'b1));
    dresp.addr_ok = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid WAIT1 stall", 96'(stall), 96'(1'b1));
    dresp   = '0;
    dreq_in = '0;
    reset   = 1'b1;
    #1;
    check("rst_mid reset-cycle stall", 96'(stall), 96'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    dresp.data_ok = 1'b1;
    dresp.data    = 32'hBAD0_BAD0;
    @(negedge clk);
    dresp = '0;
    #1;
    check("rst_mid rdata", 96'(rdata), 96'(0));
    check("rst_mid stall", 96'(stall), 96'(1'b0));
    check("rst_mid dreq", 96'(dreq), 96'(0));
    exp_rdata = '0;

    // No valid slot for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("idle stall", 96'(stall), 96'(1'b0));
      check("idle valid", 96'(dreq.valid), 96'(1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
